// File: rtl/riscv_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_div_pkg
// Description : Shared op-field layout, FSM encoding and legal configuration
//               values for the iterative RISC-V divider.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_div_pkg;

   // Bit positions inside the 3-bit {word, rem, unsigned} op field
   localparam int c_op_uns  = 0;
   localparam int c_op_rem  = 1;
   localparam int c_op_word = 2;

   localparam int c_word_w  = 32;

   localparam int c_xlen_32 = 32;
   localparam int c_xlen_64 = 64;
   localparam int c_bpc_1   = 1;
   localparam int c_bpc_2   = 2;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_CALC = 2'd1,
      DIV_FIX  = 2'd2
   } div_state_e;

endpackage : riscv_div_pkg
`default_nettype wire

// File: rtl/riscv_div_step.sv
`default_nettype none
// ============================================================================
// Module      : riscv_div_step
// Description : Combinational BPC-bit restoring shift-subtract divider step.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_div_step
   import riscv_div_pkg::*;
#(
   parameter int XLEN = 64,
   parameter int BPC  = 1
) (
   input  logic [XLEN-1:0] i_rem,
   input  logic [XLEN-1:0] i_quo,
   input  logic [XLEN-1:0] i_div,
   output logic [XLEN-1:0] o_rem,
   output logic [XLEN-1:0] o_quo
);

   logic [XLEN-1:0] w_rem [0:BPC];
   logic [XLEN-1:0] w_quo [0:BPC];

   assign w_rem[0] = i_rem;
   assign w_quo[0] = i_quo;

   // The partial remainder stays below the divisor, so one extra bit is
   // enough to hold the shifted value and its borrow.
   for (genvar g = 0; g < BPC; g++) begin : g_bit
      logic [XLEN:0] w_shift;
      logic [XLEN:0] w_diff;

      assign w_shift      = {w_rem[g], w_quo[g][XLEN-1]};
      assign w_diff       = w_shift - {1'b0, i_div};
      assign w_rem[g+1]   = w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
      assign w_quo[g+1]   = {w_quo[g][XLEN-2:0], ~w_diff[XLEN]};
   end

   assign o_rem = w_rem[BPC];
   assign o_quo = w_quo[BPC];

endmodule : riscv_div_step
`default_nettype wire

// File: rtl/riscv_iter_divider.sv
`default_nettype none
// ============================================================================
// Module      : riscv_iter_divider
// Description : Iterative RISC-V DIV/DIVU/REM/REMU (+W) unit, BPC bits/cycle.
//               Optional macro RISCV_DIV_EARLY_OUT_EN: divide-by-zero and
//               signed overflow skip the iteration phase.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_iter_divider
   import riscv_div_pkg::*;
#(
   parameter int XLEN = 64,
   parameter int BPC  = 1
) (
   input  logic            i_riscv_div_clk,
   input  logic            i_riscv_div_rst,
   input  logic            i_riscv_div_start,
   input  logic            i_riscv_div_kill,
   input  logic [2:0]      i_riscv_div_op,
   input  logic [XLEN-1:0] i_riscv_div_rs1data,
   input  logic [XLEN-1:0] i_riscv_div_rs2data,
   output logic            o_riscv_div_busy,
   output logic            o_riscv_div_valid,
   output logic [XLEN-1:0] o_riscv_div_result
);

   localparam logic [1:0] c_st_idle = DIV_IDLE;
   localparam logic [1:0] c_st_calc = DIV_CALC;
   localparam logic [1:0] c_st_fix  = DIV_FIX;

   localparam int c_n_full = XLEN / BPC;
   localparam int c_n_word = c_word_w / BPC;
   localparam int c_cnt_w  = $clog2(c_n_full);

   logic [1:0]         r_state;
   logic [c_cnt_w-1:0] r_cnt;
   logic [c_cnt_w-1:0] r_last;
   logic [XLEN-1:0]    r_rem;
   logic [XLEN-1:0]    r_quo;
   logic [XLEN-1:0]    r_div;
   logic [XLEN-1:0]    r_a;
   logic               r_qneg;
   logic               r_rneg;
   logic               r_rem_op;
   logic               r_word;
   logic               r_dz;
   logic               r_ovf;
   logic               r_valid;
   logic [XLEN-1:0]    r_result;

   logic               w_word;
   logic               w_uns;
   logic [XLEN-1:0]    w_rs1_x;
   logic [XLEN-1:0]    w_rs2_x;
   logic               w_s1;
   logic               w_s2;
   logic [XLEN-1:0]    w_a_mag;
   logic [XLEN-1:0]    w_b_mag;
   logic [XLEN-1:0]    w_min_in;
   logic               w_dz;
   logic               w_ovf;
   logic [XLEN-1:0]    w_rem_nxt;
   logic [XLEN-1:0]    w_quo_nxt;
   logic [XLEN-1:0]    w_q_val;
   logic [XLEN-1:0]    w_r_val;
   logic [XLEN-1:0]    w_pre;
   logic [XLEN-1:0]    w_final;

   assign w_word = (XLEN == c_xlen_64) && i_riscv_div_op[c_op_word];
   assign w_uns  = i_riscv_div_op[c_op_uns];

   generate
      if (XLEN == c_xlen_64) begin : g_xlen64
         assign w_rs1_x = w_word ? {{(XLEN-c_word_w){~w_uns & i_riscv_div_rs1data[c_word_w-1]}},
                                    i_riscv_div_rs1data[c_word_w-1:0]}
                                 : i_riscv_div_rs1data;
         assign w_rs2_x = w_word ? {{(XLEN-c_word_w){~w_uns & i_riscv_div_rs2data[c_word_w-1]}},
                                    i_riscv_div_rs2data[c_word_w-1:0]}
                                 : i_riscv_div_rs2data;
         assign w_final = r_word ? {{(XLEN-c_word_w){w_pre[c_word_w-1]}}, w_pre[c_word_w-1:0]}
                                 : w_pre;
      end else begin : g_xlen32
         assign w_rs1_x = i_riscv_div_rs1data;
         assign w_rs2_x = i_riscv_div_rs2data;
         assign w_final = w_pre;
      end
   endgenerate

   // After word extension the sign always sits in the top bit
   assign w_s1    = ~w_uns & w_rs1_x[XLEN-1];
   assign w_s2    = ~w_uns & w_rs2_x[XLEN-1];
   assign w_a_mag = w_s1 ? -w_rs1_x : w_rs1_x;
   assign w_b_mag = w_s2 ? -w_rs2_x : w_rs2_x;

   assign w_min_in = w_word ? (XLEN'(1) << (c_word_w - 1)) : (XLEN'(1) << (XLEN - 1));
   assign w_dz     = (w_rs2_x == '0);
   assign w_ovf    = w_s1 & (w_a_mag == w_min_in) & (&w_rs2_x);

   riscv_div_step #(
      .XLEN (XLEN),
      .BPC  (BPC)
   ) u_step (
      .i_rem (r_rem),
      .i_quo (r_quo),
      .i_div (r_div),
      .o_rem (w_rem_nxt),
      .o_quo (w_quo_nxt)
   );

   always_comb begin
      w_q_val = r_qneg ? -r_quo : r_quo;
      w_r_val = r_rneg ? -r_rem : r_rem;
      if (r_dz) begin
         w_q_val = '1;
         w_r_val = r_rneg ? -r_a : r_a;
      end else if (r_ovf) begin
         w_q_val = r_word ? (XLEN'(1) << (c_word_w - 1)) : (XLEN'(1) << (XLEN - 1));
         w_r_val = '0;
      end
      w_pre = r_rem_op ? w_r_val : w_q_val;
   end

   always_ff @(posedge i_riscv_div_clk) begin
      if (!i_riscv_div_rst) begin
         r_state  <= c_st_idle;
         r_cnt    <= '0;
         r_last   <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_div    <= '0;
         r_a      <= '0;
         r_qneg   <= 1'b0;
         r_rneg   <= 1'b0;
         r_rem_op <= 1'b0;
         r_word   <= 1'b0;
         r_dz     <= 1'b0;
         r_ovf    <= 1'b0;
         r_valid  <= 1'b0;
         r_result <= '0;
      end else begin
         r_valid <= 1'b0;
         if (i_riscv_div_kill) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
         end else begin
            case (r_state)
               c_st_idle: begin
                  if (i_riscv_div_start) begin
                     r_rem    <= '0;
                     // Word dividends are pre-shifted so 32 steps consume them
                     r_quo    <= w_word ? (w_a_mag << c_word_w) : w_a_mag;
                     r_div    <= w_b_mag;
                     r_a      <= w_a_mag;
                     r_qneg   <= w_s1 ^ w_s2;
                     r_rneg   <= w_s1;
                     r_rem_op <= i_riscv_div_op[c_op_rem];
                     r_word   <= w_word;
                     r_dz     <= w_dz;
                     r_ovf    <= w_ovf;
                     r_cnt    <= '0;
                     r_last   <= w_word ? c_cnt_w'(c_n_word - 1) : c_cnt_w'(c_n_full - 1);
`ifdef RISCV_DIV_EARLY_OUT_EN
                     r_state  <= (w_dz | w_ovf) ? c_st_fix : c_st_calc;
`else
                     r_state  <= c_st_calc;
`endif
                  end
               end
               c_st_calc: begin
                  r_rem <= w_rem_nxt;
                  r_quo <= w_quo_nxt;
                  if (r_cnt == r_last) begin
                     r_state <= c_st_fix;
                     r_cnt   <= '0;
                  end else begin
                     r_cnt <= r_cnt + c_cnt_w'(1);
                  end
               end
               c_st_fix: begin
                  r_state  <= c_st_idle;
                  r_valid  <= 1'b1;
                  r_result <= w_final;
               end
               default: r_state <= c_st_idle;
            endcase
         end
      end
   end

   assign o_riscv_div_busy   = (r_state != c_st_idle);
   assign o_riscv_div_valid  = r_valid;
   assign o_riscv_div_result = r_result;

endmodule : riscv_iter_divider
`default_nettype wire
